// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// prefix_next is the KMP-style transition used by the RTL.
package seqdet_pkg;

  localparam int MAX_N = 16;
  localparam int PW = 5;
  localparam logic [3:0] DEF_PAT = 4'b1101;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_SHIFT,
    ACT_LOAD
  } edge_act_e;

  function automatic int sw_width(input int n);
    return $clog2(n + 1);
  endfunction

  // pat is right-aligned in [n-1:0]; its MSB is the first bit of the pattern.
  function automatic logic [PW-1:0] prefix_next(input logic [MAX_N-1:0] pat,
                                                input int n,
                                                input logic [PW-1:0] p,
                                                input logic b,
                                                input logic ovl);
    logic [PW-1:0] nxt;
    int q;
    logic ok;
    nxt = '0;
    q = (int'(p) == n && !ovl) ? 0 : int'(p);
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n && k <= q + 1) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_N; j++) begin
          int idx;
          logic sBit;
          idx = q + 1 - k + j;
          sBit = 1'b0;
          if (j < k) begin
            sBit = (idx == q) ? b : pat[4'(n - 1 - idx)];
            if (sBit != pat[4'(n - 1 - j)]) ok = 1'b0;
          end
        end
        if (ok) nxt = PW'(k);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seqdet_param.sv
// Serial N-bit pattern detector with loadable pattern, overlap select,
// valid-qualified input and a saturating match counter.
module seqdet_param
  import seqdet_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   DEF_PAT = N'(seqdet_pkg::DEF_PAT),
  parameter int             CNT_W   = 8,
  localparam int            SW      = sw_width(N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din_vld,
  input  logic             din,
  input  logic             mode_ovl,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [SW-1:0]    stat,
  output logic [CNT_W-1:0] match_cnt
);

  logic [N-1:0]  pat_q, pat_d;
  logic [SW-1:0] p_q, p_d;
  logic          inc;
  edge_act_e     act;

  // A pattern load always wins and discards any bit offered in the same cycle.
  always_comb begin
    pat_d = pat_q;
    p_d   = p_q;
    inc   = 1'b0;
    act   = ACT_HOLD;
    if (pat_load) begin
      act = ACT_LOAD;
    end else if (din_vld) begin
      act = ACT_SHIFT;
    end
    unique case (act)
      ACT_LOAD: begin
        pat_d = pat_in;
        p_d   = '0;
      end
      ACT_SHIFT: begin
        p_d = SW'(prefix_next(MAX_N'(pat_q), N, PW'(p_q), din, mode_ovl));
        inc = (p_d == SW'(N));
      end
      default: begin
        p_d = p_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pat_q <= DEF_PAT;
      p_q   <= '0;
    end else begin
      pat_q <= pat_d;
      p_q   <= p_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i(clk),
    .rst_i(clr),
    .inc_i(inc),
    .clr_i(cnt_clr),
    .cnt_o(match_cnt)
  );

  assign dout = (p_q == SW'(N));
  assign stat = p_q;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed self-checking bench for seqdet_param: default instance plus a
// narrow-counter all-ones instance for saturation checks.
module tb_seqdet_param;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       dinVld = 1'b0;
  logic       din = 1'b0;
  logic       modeOvl = 1'b1;
  logic       patLoad = 1'b0;
  logic [3:0] patIn = 4'b0000;
  logic       cntClr = 1'b0;
  logic       dout;
  logic [2:0] stat;
  logic [7:0] matchCnt;

  logic       bDinVld = 1'b0;
  logic       bDin = 1'b0;
  logic       bCntClr = 1'b0;
  logic       bDout;
  logic [2:0] bStat;
  logic [1:0] bCnt;

  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  seqdet_param u_dut (
    .clk(clk), .clr(clr), .din_vld(dinVld), .din(din), .mode_ovl(modeOvl),
    .pat_load(patLoad), .pat_in(patIn), .cnt_clr(cntClr),
    .dout(dout), .stat(stat), .match_cnt(matchCnt)
  );

  seqdet_param #(.N(4), .DEF_PAT(4'b1111), .CNT_W(2)) u_sat (
    .clk(clk), .clr(clr), .din_vld(bDinVld), .din(bDin), .mode_ovl(1'b1),
    .pat_load(1'b0), .pat_in(4'b0000), .cnt_clr(bCntClr),
    .dout(bDout), .stat(bStat), .match_cnt(bCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic d);
    dinVld = vld;
    din = d;
    @(posedge clk);
    #1;
    dinVld = 1'b0;
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput({tag, " rst stat"}, 32'(stat), 0);
    checkOutput({tag, " rst dout"}, 32'(dout), 0);
    checkOutput({tag, " rst cnt"}, 32'(matchCnt), 0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // es holds the expected stat after each bit, one hex digit per bit, first bit leftmost.
  task automatic runStream(input string tag, input logic [6:0] bits, input logic [27:0] es);
    for (int i = 0; i < 7; i++) begin
      logic [3:0] e;
      e = es[27-4*i -: 4];
      applyStimulus(1'b1, bits[6-i]);
      checkOutput($sformatf("%s stat b%0d", tag, i + 1), 32'(stat), 32'(e));
      checkOutput($sformatf("%s dout b%0d", tag, i + 1), 32'(dout), 32'(e == 4'd4));
    end
  endtask

  initial begin
    logic [31:0] bStatExp;
    logic [31:0] bCntExp;

    // Overlap, default pattern 1101
    doReset("ovl");
    modeOvl = 1'b1;
    runStream("ovl", 7'b1101101, 28'h1234234);
    checkOutput("ovl cnt", 32'(matchCnt), 2);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle stat", 32'(stat), 4);
    checkOutput("idle dout", 32'(dout), 1);

    // Non-overlap
    doReset("novl");
    modeOvl = 1'b0;
    runStream("novl", 7'b1101101, 28'h1234101);
    checkOutput("novl cnt", 32'(matchCnt), 1);

    // Run of ones exercising the state-2 self-loop
    doReset("ones");
    modeOvl = 1'b1;
    runStream("ones", 7'b1111101, 28'h1222234);
    checkOutput("ones cnt", 32'(matchCnt), 1);

    // Pattern load beats a simultaneous valid bit; counter survives the load
    applyStimulus(1'b1, 1'b1);
    checkOutput("preload stat", 32'(stat), 2);
    patLoad = 1'b1;
    patIn = 4'b0110;
    applyStimulus(1'b1, 1'b0);
    patLoad = 1'b0;
    checkOutput("load stat", 32'(stat), 0);
    checkOutput("load cnt", 32'(matchCnt), 1);
    runStream("load", 7'b0110110, 28'h1234234);
    checkOutput("load cnt2", 32'(matchCnt), 3);

    // Asynchronous clear mid-pattern
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("preclr stat", 32'(stat), 3);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("aclr stat", 32'(stat), 0);
    checkOutput("aclr dout", 32'(dout), 0);
    checkOutput("aclr pat", 32'(u_dut.pat_q), 32'(4'b1101));
    checkOutput("aclr cnt", 32'(matchCnt), 0);
    @(negedge clk);
    clr = 1'b0;
    runStream("postclr", 7'b1101101, 28'h1234234);

    // Saturation on the 2-bit counter, pattern 1111
    bStatExp = 32'h12344444;
    bCntExp = 32'h00012333;
    for (int i = 0; i < 8; i++) begin
      bDinVld = 1'b1;
      bDin = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat stat b%0d", i + 1), 32'(bStat), 32'(bStatExp[31-4*i -: 4]));
      checkOutput($sformatf("sat cnt b%0d", i + 1), 32'(bCnt), 32'(bCntExp[31-4*i -: 4]));
    end
    bCntClr = 1'b1;
    @(posedge clk);
    #1;
    bCntClr = 1'b0;
    checkOutput("clr+inc cnt", 32'(bCnt), 0);
    checkOutput("clr+inc dout", 32'(bDout), 1);
    @(posedge clk);
    #1;
    bDinVld = 1'b0;
    checkOutput("after clr cnt", 32'(bCnt), 1);
    bCntClr = 1'b1;
    @(posedge clk);
    #1;
    bCntClr = 1'b0;
    checkOutput("clr only cnt", 32'(bCnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
